// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and its surroundings:
// PLL status/control, domain resets and status readback.
`timescale 1ns/1ps
interface pll_lock_supervisor_if #(
  parameter int CNT_W = 8
);
  logic             pll_locked;
  logic             sw_restart;
  logic             err_clr;
  logic             pll_areset;
  logic [3:0]       domain_rst_n;
  logic             ready;
  logic [CNT_W-1:0] lock_loss_cnt;
  logic             timeout_err;

  modport master (
    output pll_locked, sw_restart, err_clr,
    input  pll_areset, domain_rst_n, ready, lock_loss_cnt, timeout_err
  );

  modport slave (
    input  pll_locked, sw_restart, err_clr,
    output pll_areset, domain_rst_n, ready, lock_loss_cnt, timeout_err
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies lock, then
// releases the four output-clock domain resets in staggered order.
//
// state       | meaning
// RESET_PLL   | pll_areset high for ARESET_CYCLES, all domains held
// WAIT_LOCK   | waiting for synchronized lock, bounded by RELOCK_TIMEOUT
// STABLE      | counting consecutive locked cycles
// RELEASE     | raising domain_rst_n bits 0..3, RST_STAGGER apart
// RUN         | all domains released, ready high
`timescale 1ns/1ps
module pll_lock_supervisor #(
  parameter int LOCK_STABLE_CYCLES = 1000,
  parameter int ARESET_CYCLES      = 10,
  parameter int RELOCK_TIMEOUT     = 10000,
  parameter int RST_STAGGER        = 16,
  parameter int CNT_W              = 8
) (
  input  logic inclk0,
  input  logic rst_n,
  pll_lock_supervisor_if.slave bus
);

  localparam int M1   = (ARESET_CYCLES > RELOCK_TIMEOUT) ? ARESET_CYCLES : RELOCK_TIMEOUT;
  localparam int M2   = (LOCK_STABLE_CYCLES > RST_STAGGER) ? LOCK_STABLE_CYCLES : RST_STAGGER;
  localparam int MAXC = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             sync1, lk_s;
  logic             areset_q, areset_nx;
  logic [3:0]       dom_q, dom_nx;
  logic             ready_q, ready_nx;
  logic [CNT_W-1:0] loss_q, loss_nx;
  logic             to_q, to_nx;
  logic             lost, restart, loss_inc, to_set;

  // pll_locked comes from the PLL's own domain
  always_ff @(posedge inclk0 or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      lk_s  <= 1'b0;
    end else begin
      sync1 <= bus.pll_locked;
      lk_s  <= sync1;
    end
  end

  always_ff @(posedge inclk0 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_RESET_PLL;
      cnt      <= '0;
      areset_q <= 1'b1;
      dom_q    <= 4'b0000;
      ready_q  <= 1'b0;
      loss_q   <= '0;
      to_q     <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      areset_q <= areset_nx;
      dom_q    <= dom_nx;
      ready_q  <= ready_nx;
      loss_q   <= loss_nx;
      to_q     <= to_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    areset_nx = areset_q;
    dom_nx    = dom_q;
    ready_nx  = ready_q;
    loss_inc  = 1'b0;
    to_set    = 1'b0;
    lost      = ((state == S_RELEASE) || (state == S_RUN)) && !lk_s;
    restart   = bus.sw_restart && (state != S_RESET_PLL);

    if (lost || restart) begin
      state_nx  = S_RESET_PLL;
      cnt_nx    = '0;
      areset_nx = 1'b1;
      dom_nx    = 4'b0000;
      ready_nx  = 1'b0;
      loss_inc  = lost;
    end else begin
      unique case (state)
        S_RESET_PLL: begin
          if (cnt == CW'(ARESET_CYCLES - 1)) begin
            state_nx  = S_WAIT_LOCK;
            cnt_nx    = '0;
            areset_nx = 1'b0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (lk_s) begin
            state_nx = S_STABLE;
            cnt_nx   = '0;
          end else if (cnt == CW'(RELOCK_TIMEOUT - 1)) begin
            state_nx  = S_RESET_PLL;
            cnt_nx    = '0;
            areset_nx = 1'b1;
            to_set    = 1'b1;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        S_STABLE: begin
          if (!lk_s) begin
            state_nx = S_WAIT_LOCK;
            cnt_nx   = '0;
          end else if (cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
            state_nx = S_RELEASE;
            cnt_nx   = '0;
            dom_nx   = 4'b0001;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        S_RELEASE: begin
          // one more stagger interval after bit 3 before declaring ready
          if (cnt == CW'(RST_STAGGER - 1)) begin
            cnt_nx = '0;
            if (dom_q == 4'b1111) begin
              state_nx = S_RUN;
              ready_nx = 1'b1;
            end else begin
              dom_nx = {dom_q[2:0], 1'b1};
            end
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        S_RUN: begin
          ready_nx = 1'b1;
        end
        default: begin
          state_nx  = S_RESET_PLL;
          cnt_nx    = '0;
          areset_nx = 1'b1;
          dom_nx    = 4'b0000;
          ready_nx  = 1'b0;
        end
      endcase
    end

    if (loss_inc) begin
      if (bus.err_clr)       loss_nx = CNT_W'(1);
      else if (&loss_q)      loss_nx = loss_q;
      else                   loss_nx = loss_q + CNT_W'(1);
    end else if (bus.err_clr) begin
      loss_nx = '0;
    end else begin
      loss_nx = loss_q;
    end

    if (to_set)            to_nx = 1'b1;
    else if (bus.err_clr)  to_nx = 1'b0;
    else                   to_nx = to_q;
  end

  assign bus.pll_areset    = areset_q;
  assign bus.domain_rst_n  = dom_q;
  assign bus.ready         = ready_q;
  assign bus.lock_loss_cnt = loss_q;
  assign bus.timeout_err   = to_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios plus a randomized run
// compared against a phase/age reference model.
`timescale 1ns/1ps
module tb_pll_lock_supervisor;
  localparam int LS = 8, AR = 4, TO = 50, ST = 2, CW = 8;
  localparam int READY_NOM = AR + 2 + LS + 4 * ST;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;

  pll_lock_supervisor_if #(.CNT_W(CW)) bus();

  pll_lock_supervisor #(
    .LOCK_STABLE_CYCLES(LS), .ARESET_CYCLES(AR), .RELOCK_TIMEOUT(TO),
    .RST_STAGGER(ST), .CNT_W(CW)
  ) dut (
    .inclk0(clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // reference model: phase plus age in phase, outputs derived arithmetically
  localparam int P_RST = 0, P_WAIT = 1, P_STAB = 2, P_REL = 3;
  int   ph = P_RST;
  int   age = 0;
  logic m_s1 = 1'b0, m_lks = 1'b0;
  int   m_cnt = 0;
  logic m_to = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = P_RST; age = 0; m_s1 = 1'b0; m_lks = 1'b0; m_cnt = 0; m_to = 1'b0;
    end else begin
      bit loss, rs, tmo;
      loss = (ph == P_REL) && !m_lks;
      rs   = bus.sw_restart && (ph != P_RST);
      tmo  = 1'b0;
      if (loss || rs) begin
        ph = P_RST; age = 0;
      end else begin
        case (ph)
          P_RST:  begin age++; if (age == AR) begin ph = P_WAIT; age = 0; end end
          P_WAIT: if (m_lks) begin ph = P_STAB; age = 0; end
                  else begin age++; if (age == TO) begin tmo = 1'b1; ph = P_RST; age = 0; end end
          P_STAB: if (!m_lks) begin ph = P_WAIT; age = 0; end
                  else begin age++; if (age == LS) begin ph = P_REL; age = 0; end end
          default: if (age < 100000) age++;
        endcase
      end
      if (loss) m_cnt = bus.err_clr ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX);
      else if (bus.err_clr) m_cnt = 0;
      if (tmo) m_to = 1'b1;
      else if (bus.err_clr) m_to = 1'b0;
      m_lks = m_s1;
      m_s1  = bus.pll_locked;
    end
  end

  function automatic logic [3:0] m_dom();
    int n;
    if (ph != P_REL) return 4'b0000;
    n = age / ST + 1;
    if (n > 4) n = 4;
    return 4'((1 << n) - 1);
  endfunction

  function automatic logic m_ready();
    return (ph == P_REL) && (age >= 4 * ST);
  endfunction

  task automatic apply_reset(input logic locked);
    rst_n = 1'b0;
    bus.pll_locked = locked;
    bus.sw_restart = 1'b0;
    bus.err_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.pll_locked = 1'b1; bus.sw_restart = 1'b0; bus.err_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (bus.pll_areset !== 1'b1) begin n_fail++; $display("FAIL reset_areset got %b want 1", bus.pll_areset); end
    n_chk++; if (bus.domain_rst_n !== 4'b0000) begin n_fail++; $display("FAIL reset_dom got %b want 0000", bus.domain_rst_n); end
    n_chk++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", bus.ready); end
    n_chk++; if (bus.lock_loss_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", bus.lock_loss_cnt); end
    n_chk++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b want 0", bus.timeout_err); end
  endtask

  task automatic test_clean_start();
    int hi = 0, bad = 0, k1 = -1, k3 = -1, k7 = -1, kf = -1, kr = -1;
    logic [3:0] prev = 4'b0000, d;
    apply_reset(1'b1);
    for (int k = 0; k < 40; k++) begin
      if (bus.pll_areset === 1'b1) hi++;
      d = bus.domain_rst_n;
      if (d !== prev && d !== ((prev << 1) | 4'b0001)) bad++;
      if (d === 4'b0001 && k1 < 0) k1 = k;
      if (d === 4'b0011 && k3 < 0) k3 = k;
      if (d === 4'b0111 && k7 < 0) k7 = k;
      if (d === 4'b1111 && kf < 0) kf = k;
      if (bus.ready === 1'b1 && kr < 0) kr = k;
      prev = d;
      @(negedge clk);
    end
    n_chk++; if (hi != AR) begin n_fail++; $display("FAIL start_areset_width got %0d want %0d", hi, AR); end
    n_chk++; if (kr < READY_NOM - 1 || kr > READY_NOM + 1) begin n_fail++; $display("FAIL start_ready_time got %0d want %0d+-1", kr, READY_NOM); end
    n_chk++; if (k3 - k1 != ST) begin n_fail++; $display("FAIL start_step01 got %0d want %0d", k3 - k1, ST); end
    n_chk++; if (k7 - k3 != ST) begin n_fail++; $display("FAIL start_step12 got %0d want %0d", k7 - k3, ST); end
    n_chk++; if (kf - k7 != ST) begin n_fail++; $display("FAIL start_step23 got %0d want %0d", kf - k7, ST); end
    n_chk++; if (kr - kf != ST) begin n_fail++; $display("FAIL start_ready_after_all got %0d want %0d", kr - kf, ST); end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL start_order got %0d bad steps want 0", bad); end
    n_chk++; if (bus.lock_loss_cnt !== 8'd0) begin n_fail++; $display("FAIL start_cnt got %0d want 0", bus.lock_loss_cnt); end
  endtask

  task automatic test_lock_drop_run();
    int lat = -1, hi = 0, rr = -1;
    bus.pll_locked = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (lat < 0 && bus.domain_rst_n === 4'b0000 && bus.ready === 1'b0) lat = n;
      if (bus.pll_areset === 1'b1) hi++;
      if (n > 5 && rr < 0 && bus.ready === 1'b1) rr = n;
      if (n == 5) bus.pll_locked = 1'b1;
    end
    n_chk++; if (lat < 1 || lat > 3) begin n_fail++; $display("FAIL drop_latency got %0d edges want 1..3", lat); end
    n_chk++; if (bus.lock_loss_cnt !== 8'd1) begin n_fail++; $display("FAIL drop_cnt got %0d want 1", bus.lock_loss_cnt); end
    n_chk++; if (hi != AR) begin n_fail++; $display("FAIL drop_areset_width got %0d want %0d", hi, AR); end
    n_chk++; if (rr < 0 || bus.domain_rst_n !== 4'b1111) begin n_fail++; $display("FAIL drop_resequence ready_at=%0d dom=%b want ready and 1111", rr, bus.domain_rst_n); end
  endtask

  task automatic test_glitch_stable();
    int early = 0, rel = -1;
    apply_reset(1'b0);
    for (int b = 0; b < 20 && bus.pll_areset !== 1'b0; b++) @(negedge clk);
    n_chk++; if (bus.pll_areset !== 1'b0) begin n_fail++; $display("FAIL glitch_wait_areset got %b want 0", bus.pll_areset); end
    bus.pll_locked = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      n_chk++;
      if (bus.domain_rst_n !== m_dom() || bus.ready !== m_ready() || bus.pll_areset !== (ph == P_RST)
          || bus.lock_loss_cnt !== CW'(m_cnt) || bus.timeout_err !== m_to) begin
        n_fail++;
        $display("FAIL glitch_model n=%0d dom %b want %b ready %b want %b areset %b want %b cnt %0d want %0d",
                 n, bus.domain_rst_n, m_dom(), bus.ready, m_ready(), bus.pll_areset, (ph == P_RST), bus.lock_loss_cnt, m_cnt);
      end
      if (n < 10 + LS && bus.domain_rst_n !== 4'b0000) early++;
      if (rel < 0 && bus.domain_rst_n === 4'b0001) rel = n;
      if (n == 8) bus.pll_locked = 1'b0;
      if (n == 10) bus.pll_locked = 1'b1;
    end
    n_chk++; if (early != 0) begin n_fail++; $display("FAIL glitch_early_release got %0d cycles want 0", early); end
    n_chk++; if (rel < 10 + LS || rel > 10 + LS + 4) begin n_fail++; $display("FAIL glitch_release_time got %0d want %0d..%0d", rel, 10 + LS, 14 + LS); end
    n_chk++; if (bus.lock_loss_cnt !== 8'd0) begin n_fail++; $display("FAIL glitch_cnt got %0d want 0", bus.lock_loss_cnt); end
  endtask

  task automatic test_never_locks();
    int r[$];
    logic prev = 1'b1, a;
    int t1 = -1, clr_at = -1;
    logic to_r2 = 1'b0;
    apply_reset(1'b0);
    for (int n = 0; n < 200; n++) begin
      a = bus.pll_areset;
      if (a === 1'b1 && prev === 1'b0) begin
        r.push_back(n);
        if (r.size() == 3) to_r2 = bus.timeout_err;
      end
      prev = a;
      if (bus.timeout_err === 1'b1 && t1 < 0) t1 = n;
      if (r.size() == 2 && clr_at < 0) clr_at = n + 3;
      if (n == clr_at) bus.err_clr = 1'b1;
      if (n == clr_at + 1) bus.err_clr = 1'b0;
      if (clr_at >= 0 && n == clr_at + 2) begin
        n_chk++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_clear got %b want 0", bus.timeout_err); end
      end
      @(negedge clk);
    end
    n_chk++;
    if (r.size() < 3) begin
      n_fail++; $display("FAIL timeout_pulses got %0d rises want 3", r.size());
    end else begin
      if (r[1] - r[0] != AR + TO || r[2] - r[1] != AR + TO) begin
        n_fail++; $display("FAIL timeout_period got %0d,%0d want %0d", r[1] - r[0], r[2] - r[1], AR + TO);
      end
      n_chk++; if (t1 != r[0]) begin n_fail++; $display("FAIL timeout_first got %0d want %0d", t1, r[0]); end
      n_chk++; if (r[0] != AR + TO) begin n_fail++; $display("FAIL timeout_first_rise got %0d want %0d", r[0], AR + TO); end
    end
    n_chk++; if (to_r2 !== 1'b1) begin n_fail++; $display("FAIL timeout_reset_again got %b want 1", to_r2); end
  endtask

  task automatic test_saturation();
    int b, exp_c;
    apply_reset(1'b1);
    for (int i = 0; i < 260; i++) begin
      for (b = 0; b < 80 && bus.domain_rst_n[0] !== 1'b1; b++) @(negedge clk);
      if (b >= 80) begin
        n_chk++; n_fail++; $display("FAIL sat_wait_release iter=%0d got no release want release", i);
        break;
      end
      bus.pll_locked = 1'b0;
      repeat (3) @(negedge clk);
      bus.pll_locked = 1'b1;
      exp_c = (i + 1 < CNT_MAX) ? i + 1 : CNT_MAX;
      n_chk++; if (bus.lock_loss_cnt !== CW'(exp_c)) begin n_fail++; $display("FAIL sat_cnt iter=%0d got %0d want %0d", i, bus.lock_loss_cnt, exp_c); end
    end
    bus.err_clr = 1'b1; @(negedge clk); bus.err_clr = 1'b0;
    n_chk++; if (bus.lock_loss_cnt !== 8'd0) begin n_fail++; $display("FAIL errclr_cnt got %0d want 0", bus.lock_loss_cnt); end

    for (b = 0; b < 80 && bus.domain_rst_n[0] !== 1'b1; b++) @(negedge clk);
    bus.pll_locked = 1'b0;
    @(negedge clk); @(negedge clk);
    bus.sw_restart = 1'b1;
    @(negedge clk);
    bus.sw_restart = 1'b0; bus.pll_locked = 1'b1;
    n_chk++; if (bus.lock_loss_cnt !== 8'd1 || bus.domain_rst_n !== 4'b0000) begin n_fail++; $display("FAIL loss_with_restart cnt %0d dom %b want 1 0000", bus.lock_loss_cnt, bus.domain_rst_n); end

    for (b = 0; b < 80 && bus.domain_rst_n[0] !== 1'b1; b++) @(negedge clk);
    bus.pll_locked = 1'b0;
    @(negedge clk); @(negedge clk);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0; bus.pll_locked = 1'b1;
    n_chk++; if (bus.lock_loss_cnt !== 8'd1) begin n_fail++; $display("FAIL loss_with_errclr got %0d want 1", bus.lock_loss_cnt); end

    for (b = 0; b < 80 && bus.ready !== 1'b1; b++) @(negedge clk);
    n_chk++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL restart_wait_run got %b want 1", bus.ready); end
    bus.sw_restart = 1'b1; @(negedge clk); bus.sw_restart = 1'b0;
    n_chk++;
    if (bus.domain_rst_n !== 4'b0000 || bus.ready !== 1'b0 || bus.pll_areset !== 1'b1 || bus.lock_loss_cnt !== 8'd1) begin
      n_fail++; $display("FAIL sw_restart_run dom %b ready %b areset %b cnt %0d want 0000 0 1 1",
                         bus.domain_rst_n, bus.ready, bus.pll_areset, bus.lock_loss_cnt);
    end
    for (b = 0; b < 80 && bus.ready !== 1'b1; b++) @(negedge clk);
    n_chk++; if (bus.ready !== 1'b1 || bus.domain_rst_n !== 4'b1111) begin n_fail++; $display("FAIL sw_restart_reseq ready %b dom %b want 1 1111", bus.ready, bus.domain_rst_n); end
  endtask

  task automatic test_mid_release_reset();
    int b, hi = 0, kr = -1;
    bus.sw_restart = 1'b1; @(negedge clk); bus.sw_restart = 1'b0;
    for (b = 0; b < 80 && bus.domain_rst_n !== 4'b0011; b++) @(negedge clk);
    n_chk++; if (bus.domain_rst_n !== 4'b0011) begin n_fail++; $display("FAIL mid_wait_0011 got %b want 0011", bus.domain_rst_n); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.pll_areset !== 1'b1 || bus.domain_rst_n !== 4'b0000 || bus.ready !== 1'b0
        || bus.lock_loss_cnt !== 8'd0 || bus.timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL mid_async_reset areset %b dom %b ready %b cnt %0d to %b want 1 0000 0 0 0",
                         bus.pll_areset, bus.domain_rst_n, bus.ready, bus.lock_loss_cnt, bus.timeout_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (bus.pll_areset === 1'b1) hi++;
      if (bus.ready === 1'b1 && kr < 0) kr = k;
      @(negedge clk);
    end
    n_chk++; if (hi != AR) begin n_fail++; $display("FAIL mid_areset_width got %0d want %0d", hi, AR); end
    n_chk++; if (kr < READY_NOM - 1 || kr > READY_NOM + 1) begin n_fail++; $display("FAIL mid_ready_time got %0d want %0d+-1", kr, READY_NOM); end
  endtask

  task automatic test_random();
    int hold = 0;
    apply_reset(1'b1);
    for (int n = 0; n < 2000; n++) begin
      n_chk++;
      if (bus.domain_rst_n !== m_dom() || bus.ready !== m_ready() || bus.pll_areset !== (ph == P_RST)
          || bus.lock_loss_cnt !== CW'(m_cnt) || bus.timeout_err !== m_to) begin
        n_fail++;
        $display("FAIL random_model n=%0d dom %b want %b ready %b want %b areset %b want %b cnt %0d want %0d to %b want %b",
                 n, bus.domain_rst_n, m_dom(), bus.ready, m_ready(), bus.pll_areset, (ph == P_RST),
                 bus.lock_loss_cnt, m_cnt, bus.timeout_err, m_to);
      end
      if (hold > 0) begin
        hold--;
      end else if (bus.pll_locked) begin
        if ($urandom_range(0, 29) == 0) begin
          bus.pll_locked = 1'b0;
          hold = ($urandom_range(0, 9) == 0) ? int'($urandom_range(40, 120)) : int'($urandom_range(0, 6));
        end
      end else begin
        bus.pll_locked = 1'b1;
        hold = $urandom_range(10, 60);
      end
      bus.sw_restart = ($urandom_range(0, 79) == 0);
      bus.err_clr    = ($urandom_range(0, 99) == 0);
      @(negedge clk);
    end
    bus.sw_restart = 1'b0;
    bus.err_clr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pll_locked = 1'b0;
    bus.sw_restart = 1'b0;
    bus.err_clr = 1'b0;
    test_reset();
    test_clean_start();
    test_lock_drop_run();
    test_glitch_stable();
    test_never_locks();
    test_saturation();
    test_mid_release_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
